// File: rtl/jogo_pkg.sv
// Shared cell codes and FSM state encodings for the ultimate tic-tac-toe macro controller.
package jogo_pkg;

   localparam logic [1:0] VAZIO         = 2'b00;
   localparam logic [1:0] CELULA_O      = 2'b01;
   localparam logic [1:0] CELULA_X      = 2'b10;
   localparam logic [1:0] CELULA_EMPATE = 2'b11;

   typedef enum logic [2:0] {
      ESCOLHE_MACRO = 3'd0,
      JOGA_MICRO    = 3'd1,
      AGUARDA       = 3'd2,
      VERIFICA      = 3'd3,
      FIM           = 3'd4
   } estado_t;

endpackage

// File: rtl/verifica_linhas.sv
// Combinational line checker: flags a complete row, column or diagonal of O or X,
// and a board with no empty cell. Tie cells never complete a line.
module verifica_linhas
   import jogo_pkg::*;
#(
   parameter int SIDE = 3
)
(
   input  logic [2*SIDE*SIDE-1:0] tabuleiro,
   output logic                   vitoria_o,
   output logic                   vitoria_x,
   output logic                   cheio
);

   localparam int CELLS = SIDE * SIDE;

   logic [SIDE-1:0] linha_o, linha_x, coluna_o, coluna_x;
   logic            diag_o, diag_x, anti_o, anti_x;

   genvar gi;
   generate
      for (gi = 0; gi < SIDE; gi++) begin : g_linha
         logic lo, lx, co, cx;
         always_comb begin
            lo = 1'b1;
            lx = 1'b1;
            co = 1'b1;
            cx = 1'b1;
            for (int j = 0; j < SIDE; j++) begin
               lo = lo & (tabuleiro[2*(gi*SIDE+j) +: 2] == CELULA_O);
               lx = lx & (tabuleiro[2*(gi*SIDE+j) +: 2] == CELULA_X);
               co = co & (tabuleiro[2*(j*SIDE+gi) +: 2] == CELULA_O);
               cx = cx & (tabuleiro[2*(j*SIDE+gi) +: 2] == CELULA_X);
            end
         end
         assign linha_o[gi]  = lo;
         assign linha_x[gi]  = lx;
         assign coluna_o[gi] = co;
         assign coluna_x[gi] = cx;
      end
   endgenerate

   // Main diagonal walks (j,j); anti-diagonal walks (j,SIDE-1-j).
   always_comb begin
      diag_o = 1'b1;
      diag_x = 1'b1;
      anti_o = 1'b1;
      anti_x = 1'b1;
      for (int j = 0; j < SIDE; j++) begin
         diag_o = diag_o & (tabuleiro[2*(j*SIDE+j) +: 2] == CELULA_O);
         diag_x = diag_x & (tabuleiro[2*(j*SIDE+j) +: 2] == CELULA_X);
         anti_o = anti_o & (tabuleiro[2*(j*SIDE+SIDE-1-j) +: 2] == CELULA_O);
         anti_x = anti_x & (tabuleiro[2*(j*SIDE+SIDE-1-j) +: 2] == CELULA_X);
      end
   end

   always_comb begin
      cheio = 1'b1;
      for (int i = 0; i < CELLS; i++) begin
         cheio = cheio & (tabuleiro[2*i +: 2] != VAZIO);
      end
   end

   assign vitoria_o = (|linha_o) | (|coluna_o) | diag_o | anti_o;
   assign vitoria_x = (|linha_x) | (|coluna_x) | diag_x | anti_x;

endmodule

// File: rtl/controle_tabuleiro_macro.sv
// Macro-board controller: validates one-hot presses, sequences macro choice, micro move
// and result write-back, and detects wins/draws. Optional idle timeout: JOGADA_TIMEOUT_EN.
module controle_tabuleiro_macro
   import jogo_pkg::*;
#(
   parameter  int SIDE           = 3,
   parameter  int TIMEOUT_CICLOS = 50000000,
   localparam int CELLS          = SIDE * SIDE,
   localparam int AW             = $clog2(CELLS)
)
(
   input  logic               clock,
   input  logic               reset,
   input  logic [CELLS-1:0]   botoes,
   input  logic [1:0]         resultado,
   input  logic               resultado_valido,
   output logic [CELLS-1:0]   macro,
   output logic [CELLS-1:0]   micro,
   output logic [AW-1:0]      endereco_macro,
   output logic               escolhe_macro,
   output logic               tem_jogada,
   output logic               erro,
   output logic               fim_jogo,
   output logic [1:0]         vencedor,
   output logic               timeout,
   output logic [2*CELLS-1:0] db_tabuleiro,
   output logic [2:0]         db_estado
);

   function automatic logic [AW-1:0] indice(input logic [CELLS-1:0] v);
      indice = '0;
      for (int i = 0; i < CELLS; i++) begin
         if (v[i]) indice = indice | AW'(i);
      end
   endfunction

   estado_t            estado_reg, estado_next;
   logic [1:0]         tabuleiro_reg [CELLS];
   logic [2*CELLS-1:0] tabuleiro_vec;
   logic [CELLS-1:0]   macro_reg, macro_next, micro_reg, micro_next;
   logic [CELLS-1:0]   botoes_reg;
   logic               algum_reg, evento_reg;
   logic               tem_jogada_reg, tem_jogada_next, erro_reg, erro_next;
   logic [1:0]         vencedor_reg, vencedor_next;
   logic               escreve;
   logic               onehot;
   logic [AW-1:0]      idx_press, idx_macro, idx_micro;
   logic               vitoria_o, vitoria_x, cheio;

   // A press event is the first cycle any button is seen after all were released.
   always_ff @(posedge clock) begin
      if (!reset) begin
         algum_reg  <= 1'b0;
         evento_reg <= 1'b0;
         botoes_reg <= '0;
      end else begin
         algum_reg  <= |botoes;
         evento_reg <= (|botoes) & ~algum_reg;
         botoes_reg <= botoes;
      end
   end

   assign onehot    = (botoes_reg != '0) && ((botoes_reg & (botoes_reg - CELLS'(1))) == '0);
   assign idx_press = indice(botoes_reg);
   assign idx_macro = indice(macro_reg);
   assign idx_micro = indice(micro_reg);

   genvar gi;
   generate
      for (gi = 0; gi < CELLS; gi++) begin : g_vec
         assign tabuleiro_vec[2*gi +: 2] = tabuleiro_reg[gi];
      end
   endgenerate

   verifica_linhas #(.SIDE(SIDE)) u_verifica (
      .tabuleiro (tabuleiro_vec),
      .vitoria_o (vitoria_o),
      .vitoria_x (vitoria_x),
      .cheio     (cheio)
   );

   always_ff @(posedge clock) begin
      if (!reset) estado_reg <= ESCOLHE_MACRO;
      else        estado_reg <= estado_next;
   end

   always_comb begin
      estado_next     = estado_reg;
      macro_next      = macro_reg;
      micro_next      = micro_reg;
      vencedor_next   = vencedor_reg;
      tem_jogada_next = 1'b0;
      erro_next       = 1'b0;
      escreve         = 1'b0;
      case (estado_reg)
         ESCOLHE_MACRO: begin
            if (evento_reg) begin
               if (onehot && tabuleiro_reg[idx_press] == VAZIO) begin
                  macro_next  = botoes_reg;
                  estado_next = JOGA_MICRO;
               end else begin
                  erro_next = 1'b1;
               end
            end
         end
         JOGA_MICRO: begin
            if (evento_reg) begin
               if (onehot) begin
                  micro_next      = botoes_reg;
                  tem_jogada_next = 1'b1;
                  estado_next     = AGUARDA;
               end else begin
                  erro_next = 1'b1;
               end
            end
         end
         AGUARDA: begin
            if (resultado_valido) begin
               escreve     = (resultado != VAZIO);
               estado_next = VERIFICA;
            end
         end
         VERIFICA: begin
            if (vitoria_o) begin
               vencedor_next = CELULA_O;
               estado_next   = FIM;
            end else if (vitoria_x) begin
               vencedor_next = CELULA_X;
               estado_next   = FIM;
            end else if (cheio) begin
               vencedor_next = CELULA_EMPATE;
               estado_next   = FIM;
            end else begin
               // The last micro cell sends the opponent to that macro cell, if still open.
               macro_next  = micro_reg;
               estado_next = (tabuleiro_reg[idx_micro] == VAZIO) ? JOGA_MICRO : ESCOLHE_MACRO;
            end
         end
         FIM: ;
         default: estado_next = ESCOLHE_MACRO;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         macro_reg      <= '0;
         micro_reg      <= '0;
         vencedor_reg   <= VAZIO;
         tem_jogada_reg <= 1'b0;
         erro_reg       <= 1'b0;
         for (int i = 0; i < CELLS; i++) tabuleiro_reg[i] <= VAZIO;
      end else begin
         macro_reg      <= macro_next;
         micro_reg      <= micro_next;
         vencedor_reg   <= vencedor_next;
         tem_jogada_reg <= tem_jogada_next;
         erro_reg       <= erro_next;
         if (escreve) tabuleiro_reg[idx_macro] <= resultado;
      end
   end

`ifdef JOGADA_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CICLOS + 1);

   logic [TW-1:0] contador_reg;
   logic          timeout_reg;

   // Counts idle cycles only while a player is expected to press something.
   always_ff @(posedge clock) begin
      if (!reset) begin
         contador_reg <= '0;
         timeout_reg  <= 1'b0;
      end else begin
         timeout_reg <= 1'b0;
         if (estado_next != estado_reg || evento_reg ||
             !(estado_reg == ESCOLHE_MACRO || estado_reg == JOGA_MICRO)) begin
            contador_reg <= '0;
         end else if (contador_reg == TW'(TIMEOUT_CICLOS - 1)) begin
            contador_reg <= '0;
            timeout_reg  <= 1'b1;
         end else begin
            contador_reg <= contador_reg + TW'(1);
         end
      end
   end

   assign timeout = timeout_reg;
`else
   assign timeout = 1'b0 & (TIMEOUT_CICLOS > 0);
`endif

   assign macro          = macro_reg;
   assign micro          = micro_reg;
   assign endereco_macro = idx_macro;
   assign escolhe_macro  = (estado_reg == ESCOLHE_MACRO);
   assign tem_jogada     = tem_jogada_reg;
   assign erro           = erro_reg;
   assign fim_jogo       = (estado_reg == FIM);
   assign vencedor       = vencedor_reg;
   assign db_tabuleiro   = tabuleiro_vec;
   assign db_estado      = estado_reg;

endmodule
